// File: rtl/mem_arbiter.sv
// Memory port arbiter: sequences cpu fetch -> optional data access -> one CE pulse over a single req/ack port.
// Optional ack timeout with NOP/zero fill and sticky bus error: define MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clk_ce,
   output logic        o_cpu_ce,
   input  logic [31:0] i_addr_i,
   output logic [31:0] o_data_i,
   input  logic [31:0] i_addr_d,
   input  logic [31:0] i_data_wr_d,
   input  logic [3:0]  i_wr_d,
   input  logic        i_rd_d,
   output logic [31:0] o_data_rd_d,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_be,
   output logic        o_mem_we,
   output logic        o_mem_req,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_ack,
   output logic        o_busy,
   output logic        o_bus_err
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_DATA  = 2'd1,
      ST_STEP  = 2'd2
   } state_t;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("mem_arbiter: TIMEOUT_CYCLES must be 1..255");
   end

   state_t      state, state_nxt;
   logic        req_nxt;
   logic        we_nxt;
   logic [3:0]  be_nxt;
   logic [31:0] addr_nxt;
   logic [31:0] wdata_nxt;
   logic [31:0] data_i_nxt;
   logic [31:0] data_rd_nxt;
   logic        cpu_ce_nxt;

   logic        tmo_hit;
   logic        done;
   logic [31:0] fetch_word;
   logic [31:0] load_word;

   // Address bits [1:0] are dropped by word alignment.
   logic        unused_addr_lsb;
   assign unused_addr_lsb = ^{i_addr_i[1:0], i_addr_d[1:0]};

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   logic [7:0] tmo_cnt;
   logic       bus_err_q;

   assign tmo_hit = o_mem_req && !i_mem_ack && (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         tmo_cnt   <= '0;
         bus_err_q <= 1'b0;
      end else begin
         if (!o_mem_req || i_mem_ack || tmo_hit)
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + 8'd1;
         if (tmo_hit)
            bus_err_q <= 1'b1;
      end
   end

   // A forced completion returns a NOP for fetches and zero for loads.
   assign fetch_word = i_mem_ack ? i_mem_rdata : NOP_INSN;
   assign load_word  = i_mem_ack ? i_mem_rdata : '0;
   assign o_bus_err  = bus_err_q;
`else
   assign tmo_hit    = 1'b0;
   assign fetch_word = i_mem_rdata;
   assign load_word  = i_mem_rdata;
   assign o_bus_err  = 1'b0;
`endif

   assign done   = o_mem_req && (i_mem_ack || tmo_hit);
   assign o_busy = (state != ST_STEP);

   always_comb begin
      state_nxt   = state;
      req_nxt     = o_mem_req;
      we_nxt      = o_mem_we;
      be_nxt      = o_mem_be;
      addr_nxt    = o_mem_addr;
      wdata_nxt   = o_mem_wdata;
      data_i_nxt  = o_data_i;
      data_rd_nxt = o_data_rd_d;
      cpu_ce_nxt  = 1'b0;

      // req low in FETCH/DATA means the access has not been issued yet.
      case (state)
         ST_FETCH: begin
            if (!o_mem_req) begin
               req_nxt  = 1'b1;
               addr_nxt = {i_addr_i[31:2], 2'b00};
               we_nxt   = 1'b0;
               be_nxt   = '0;
            end else if (done) begin
               req_nxt    = 1'b0;
               data_i_nxt = fetch_word;
               state_nxt  = ((|i_wr_d) || i_rd_d) ? ST_DATA : ST_STEP;
            end
         end
         ST_DATA: begin
            if (!o_mem_req) begin
               req_nxt  = 1'b1;
               addr_nxt = {i_addr_d[31:2], 2'b00};
               if (|i_wr_d) begin
                  we_nxt    = 1'b1;
                  be_nxt    = i_wr_d;
                  wdata_nxt = i_data_wr_d;
               end else begin
                  we_nxt = 1'b0;
                  be_nxt = '0;
               end
            end else if (done) begin
               req_nxt = 1'b0;
               we_nxt  = 1'b0;
               be_nxt  = '0;
               if (!o_mem_we)
                  data_rd_nxt = load_word;
               state_nxt = ST_STEP;
            end
         end
         ST_STEP: begin
            if (i_clk_ce) begin
               cpu_ce_nxt = 1'b1;
               state_nxt  = ST_FETCH;
            end
         end
         default: state_nxt = ST_FETCH;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= ST_FETCH;
         o_mem_req   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_be    <= '0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_data_i    <= '0;
         o_data_rd_d <= '0;
         o_cpu_ce    <= 1'b0;
      end else begin
         state       <= state_nxt;
         o_mem_req   <= req_nxt;
         o_mem_we    <= we_nxt;
         o_mem_be    <= be_nxt;
         o_mem_addr  <= addr_nxt;
         o_mem_wdata <= wdata_nxt;
         o_data_i    <= data_i_nxt;
         o_data_rd_d <= data_rd_nxt;
         o_cpu_ce    <= cpu_ce_nxt;
      end
   end

endmodule
